booth_mul_seq: RTL and testbench
================================

# booth_mul_seq

Multi-cycle signed 32×32 multiplier using radix-4 bit-pair (Booth) recoding. It sits directly upstream of the ALU and supplies the 64-bit product for the MUL opcode: LO goes to the ALU result path and HI goes to the HI output. Each run takes operands once, iterates 16 cycles, then reports completion through a start/busy/done handshake. Completed results are held stable for the datapath's Z/HI/LO capture.

## Interface
- `WIDTH`, default 32: operand width; the product is 2×WIDTH. Only 32 is required to be verified.
- `clock` in 1: single clock, rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `operand_A` in 32: multiplicand, two's complement.
- `operand_B` in 32: multiplier, two's complement (recoded operand).
- `busy` out 1: high from the accept edge until the done cycle.
- `done` out 1: one-cycle pulse when result_LO/result_HI are updated.
- `result_LO` out 32: product[31:0].
- `result_HI` out 32: product[63:32].

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:** if `start`=1 at a rising edge, register A and B, clear the 64-bit accumulator, set iteration count i=0 and go to RUN.
- **RUN:** one iteration per edge.
  - Recode triplet {B[2i+1], B[2i], B[2i−1]}, with B[−1]=0.
  - 000 and 111 select 0.
  - 001 and 010 select +M.
  - 011 selects +2M.
  - 100 selects −2M.
  - 101 and 110 select −M.
  - Partial product: 34-bit signed (M sign-extended by 2), sign-extended to 64, shifted left 2i, added to the accumulator modulo 2^64.
  - After i=15, go to DONE. Also on that edge, load result_LO and result_HI from the final accumulator.
- **DONE:** `done`=1 and `busy`=0 for exactly one cycle, then IDLE unconditionally.
- `start` in RUN or DONE is ignored, not queued.
- Operand changes after the accept edge have no effect.
- result_LO and result_HI change only on the edge entering DONE. They hold their value through later IDLE and RUN periods until the next completion.
- The product is the exact signed product, including −2^31 × −2^31, with no overflow flag.
- `clear`=0 at any time, including mid-RUN, forces IDLE immediately:
  - i=0;
  - accumulator, registered operands, result_LO, result_HI = 0;
  - busy = done = 0.
- The in-flight operation is discarded. The first start after release is accepted normally.

## Timing
- Reset values: busy=0, done=0, result_LO=0, result_HI=0, state=IDLE.
- Accept edge E0, where start=1 in IDLE: busy=1 after E0.
- Iterations occur on E1..E16. After E16, done=1, busy=0 and results are valid.
- After E17, done=0 and the block is in IDLE, able to accept start on E17 itself? **No.** E17 is the DONE→IDLE edge; the earliest new accept is E18.
- Fixed latency: 16 cycles from accept edge to done.
- Back-to-back throughput: one product per 18 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg` holds:
  - state encodings (IDLE, RUN, DONE);
  - `MUL_ITERS`=16;
  - the recode select constants (ZERO, POS1, POS2, NEG1, NEG2);
  - the MUL opcode value 4'b1011 shared with the ALU decoder.
- One sub-module: `booth_recode`, purely combinational. It takes the 3-bit triplet and a 32-bit M and produces a 34-bit signed partial product.
- The top level holds the FSM, the 4-bit iteration counter, the accumulator and the result registers. Target is 150–250 lines.

## Test plan
- **Basic:** A=7, B=6, start for one cycle → done exactly 16 cycles after the accept edge; LO=0x0000002A, HI=0x00000000; busy high for 16 cycles.
- **Sign cases:**
  - A=−5, B=3 → LO=0xFFFFFFF1, HI=0xFFFFFFFF.
  - A=−1, B=−1 → LO=0x00000001, HI=0.
- **Extremes:**
  - A=B=0x80000000 → HI=0x40000000, LO=0.
  - A=0x7FFFFFFF, B=0x80000000 → HI=0xC0000000, LO=0x80000000.
- **Handshake:**
  - Hold start high continuously and change A/B every cycle during RUN → only the first operands are used; done pulses once per 18 cycles.
  - Results hold between completions.
- **Reset mid-run:** assert clear=0 at iteration 8 → all outputs 0 immediately and state IDLE; after release, 7×6 completes correctly.
- **Randomized:** 1000 random signed pairs checked against a 64-bit signed reference product.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared state encodings, Booth recode selects and opcode constants
// for the ALU and its sequential multiplier.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} sel_e;

    localparam int MUL_ITERS = 16;
    localparam logic [3:0] OP_MUL = 4'b1011;

    // Radix-4 recode of {b[2i+1], b[2i], b[2i-1]}.
    function automatic sel_e recode(input logic [2:0] t);
        return (t == 3'b011) ? POS2 :
               (t == 3'b100) ? NEG2 :
               (t == 3'b001 || t == 3'b010) ? POS1 :
               (t == 3'b101 || t == 3'b110) ? NEG1 : ZERO;
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: start/busy/done handshake, operands and product halves
// between the datapath (master) and the multiplier (slave).
interface booth_mul_seq_if #(parameter int WIDTH = 32);

    logic             start;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_LO;
    logic [WIDTH-1:0] result_HI;

    modport master (
        output start, operand_A, operand_B,
        input  busy, done, result_LO, result_HI
    );

    modport slave (
        input  start, operand_A, operand_B,
        output busy, done, result_LO, result_HI
    );

endinterface

// File: rtl/booth_recode.sv
// booth_recode: turns one Booth triplet and the multiplicand into a signed
// partial product two bits wider than the multiplicand.
module booth_recode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       trip,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] pp
);

    sel_e             sel;
    logic [WIDTH+1:0] m1;
    logic [WIDTH+1:0] m2;

    always_comb begin
        sel = recode(trip);
        m1  = {{2{m[WIDTH-1]}}, m};
        m2  = m1 << 1;
        pp  = (sel == POS1) ? m1 :
              (sel == NEG1) ? -m1 :
              (sel == POS2) ? m2 :
              (sel == NEG2) ? -m2 : '0;
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: 16-iteration radix-4 Booth signed multiplier with a
// start/busy/done handshake; results hold until the next completion.
module booth_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic            clock,
    input logic            clear,
    booth_mul_seq_if.slave bus
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     lo_q, lo_d, hi_q, hi_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_sum, pp_sh;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           trip;
    logic [WIDTH+1:0]     pp;

    // B[-1] is the appended zero below the LSB.
    assign trip    = 3'({b_q, 1'b0} >> {cnt_q, 1'b0});
    assign pp_sh   = {{(WIDTH-2){pp[WIDTH+1]}}, pp} << {cnt_q, 1'b0};
    assign acc_sum = acc_q + pp_sh;

    booth_recode #(.WIDTH(WIDTH)) u_recode (
        .trip (trip),
        .m    (a_q),
        .pp   (pp)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                a_d     = bus.operand_A;
                b_d     = bus.operand_B;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(MUL_ITERS - 1)) begin
                    lo_d    = acc_sum[WIDTH-1:0];
                    hi_d    = acc_sum[2*WIDTH-1:WIDTH];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
        bus.result_LO = lo_q;
        bus.result_HI = hi_q;
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and randomized checks of booth_mul_seq against
// a plain 64-bit signed multiply reference.
module tb_booth_mul_seq;

    logic   clock = 1'b0;
    logic   clear;
    int     checks = 0;
    int     failures = 0;
    longint last_p = 0;

    booth_mul_seq_if #(.WIDTH(32)) bus ();

    booth_mul_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint ref_mul(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
        int   n;
        logic busy_ok;
        logic hold_ok;
        @(negedge clock);
        bus.start     = 1'b1;
        bus.operand_A = a;
        bus.operand_B = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        busy_ok   = bus.busy;
        hold_ok   = 1'b1;
        n         = 0;
        while (!bus.done && n < 40) begin
            bus.operand_A = $urandom;
            bus.operand_B = $urandom;
            bus.start     = 1'($urandom_range(0, 1));
            if ({bus.result_HI, bus.result_LO} !== 64'(last_p)) hold_ok = 1'b0;
            @(posedge clock);
            #1;
            n++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd16);
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_prod"}, {bus.result_HI, bus.result_LO}, 64'(ref_mul(a, b)));
        last_p = ref_mul(a, b);
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    endtask

    logic [31:0] opa [54];
    logic [31:0] opb [54];
    logic [31:0] edge_vals [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

    initial begin
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.operand_A = '0;
        bus.operand_B = '0;
        #2 clear = 1'b0;
        #1;
        check("reset_out", {bus.result_HI, bus.result_LO}, 64'd0);
        check("reset_hs", {62'd0, bus.busy, bus.done}, 64'd0);
        repeat (2) @(negedge clock);
        clear = 1'b1;

        do_mul(32'd7, 32'd6, "basic");
        check("basic_lo", 64'(bus.result_LO), 64'h2A);
        do_mul(-32'sd5, 32'd3, "neg5x3");
        check("neg5x3_hi_lo", {bus.result_HI, bus.result_LO}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "m1xm1");
        do_mul(32'h8000_0000, 32'h8000_0000, "minxmin");
        check("minxmin_const", {bus.result_HI, bus.result_LO}, 64'h4000_0000_0000_0000);
        do_mul(32'h7FFF_FFFF, 32'h8000_0000, "maxxmin");
        check("maxxmin_const", {bus.result_HI, bus.result_LO}, 64'hC000_0000_8000_0000);

        repeat (5) @(negedge clock);
        check("idle_hold", {bus.result_HI, bus.result_LO}, 64'(last_p));

        // Start held high with operands changing every cycle.
        for (int c = 0; c < 54; c++) begin
            @(negedge clock);
            opa[c]        = $urandom;
            opb[c]        = $urandom;
            bus.start     = 1'b1;
            bus.operand_A = opa[c];
            bus.operand_B = opb[c];
            @(posedge clock);
            #1;
            check("b2b_done", 64'(bus.done), 64'(c % 18 == 16));
            check("b2b_busy", 64'(bus.busy), 64'(c % 18 < 16));
            if (c % 18 == 16)
                check("b2b_prod", {bus.result_HI, bus.result_LO}, 64'(ref_mul(opa[c-16], opb[c-16])));
        end
        bus.start = 1'b0;
        last_p = ref_mul(opa[36], opb[36]);

        @(negedge clock);
        bus.start     = 1'b1;
        bus.operand_A = 32'h1234_5678;
        bus.operand_B = 32'h09AB_CDEF;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clock);
        #2 clear = 1'b0;
        #1;
        check("midrst_out", {bus.result_HI, bus.result_LO}, 64'd0);
        check("midrst_hs", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clock);
        clear  = 1'b1;
        last_p = 0;
        @(posedge clock);
        #1;
        check("midrst_idle", 64'(bus.busy), 64'd0);
        do_mul(32'd7, 32'd6, "post_rst");

        for (int k = 0; k < 1000; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            do_mul(a, b, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
